// File: rtl/cpu_main_memory.sv
// rtl/cpu_main_memory.sv - fixed-latency line-wide main memory responder; optional CPU_MAIN_MEMORY_BOUNDS_CHECK_EN adds out-of-range error reporting
module cpu_main_memory #(
    parameter int ADDR_WIDTH  = 32,
    parameter int LINE_WIDTH  = 128,
    parameter int DEPTH_LINES = 256,
    parameter int LATENCY     = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  mem_bus_available,
    input  logic                  mem_bus_request_read,
    input  logic                  mem_bus_request_write,
    input  logic [ADDR_WIDTH-1:0] mem_bus_request_addr,
    input  logic [LINE_WIDTH-1:0] mem_bus_request_data,
    output logic                  mem_bus_response_valid,
    output logic [ADDR_WIDTH-1:0] mem_bus_response_addr,
    output logic [LINE_WIDTH-1:0] mem_bus_response_data
`ifdef CPU_MAIN_MEMORY_BOUNDS_CHECK_EN
    ,
    output logic                  mem_bus_response_error
`endif
);

    localparam int IDX_W    = $clog2(DEPTH_LINES);
    localparam int CNT_W    = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam int CNT_INIT = (LATENCY > 1) ? LATENCY - 2 : 0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    write_q;
    logic [IDX_W-1:0]        idx_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LINE_WIDTH-1:0]   data_q;
    logic                    available_q;
    logic                    valid_q;
    logic [ADDR_WIDTH-1:0]   resp_addr_q;
    logic [LINE_WIDTH-1:0]   resp_data_q;
    logic                    commit_en;

    logic [LINE_WIDTH-1:0]   mem [DEPTH_LINES];

    logic                    accept;
    logic [IDX_W-1:0]        req_idx;
    logic                    unused_addr_bits;

    // Offset bits inside a line never select anything.
    assign unused_addr_bits = ^mem_bus_request_addr[3:0];

    assign accept  = available_q & (mem_bus_request_read | mem_bus_request_write);
    assign req_idx = mem_bus_request_addr[IDX_W+3:4];

`ifdef CPU_MAIN_MEMORY_BOUNDS_CHECK_EN
    logic oor_q;
    logic error_q;
    logic req_oor;

    assign req_oor   = (mem_bus_request_addr[ADDR_WIDTH-1:IDX_W+4] != '0);
    assign commit_en = (state_q == S_RESP) && write_q && !oor_q;
    assign mem_bus_response_error = error_q;
`else
    assign commit_en = (state_q == S_RESP) && write_q;
`endif

    assign mem_bus_available      = available_q;
    assign mem_bus_response_valid = valid_q;
    assign mem_bus_response_addr  = resp_addr_q;
    assign mem_bus_response_data  = resp_data_q;

    // Request FSM with registered outputs; the output registers lag the state by one cycle,
    // so valid lands in the cycle after RESP and available stays low through that cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            idx_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            available_q <= 1'b0;
            valid_q     <= 1'b0;
            resp_addr_q <= '0;
            resp_data_q <= '0;
`ifdef CPU_MAIN_MEMORY_BOUNDS_CHECK_EN
            oor_q       <= 1'b0;
            error_q     <= 1'b0;
`endif
        end else begin
            available_q <= 1'b0;
            valid_q     <= 1'b0;
            resp_addr_q <= '0;
            resp_data_q <= '0;
`ifdef CPU_MAIN_MEMORY_BOUNDS_CHECK_EN
            error_q     <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        // Write wins over read; a read snapshots the line at acceptance.
                        write_q <= mem_bus_request_write;
                        idx_q   <= req_idx;
                        addr_q  <= {mem_bus_request_addr[ADDR_WIDTH-1:4], 4'b0000};
                        data_q  <= mem_bus_request_write ? mem_bus_request_data : mem[req_idx];
                        cnt_q   <= CNT_W'(CNT_INIT);
                        state_q <= (LATENCY == 1) ? S_RESP : S_WAIT;
`ifdef CPU_MAIN_MEMORY_BOUNDS_CHECK_EN
                        oor_q   <= req_oor;
`endif
                    end else begin
                        available_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_RESP: begin
                    valid_q     <= 1'b1;
                    resp_addr_q <= addr_q;
`ifdef CPU_MAIN_MEMORY_BOUNDS_CHECK_EN
                    resp_data_q <= oor_q ? '0 : data_q;
                    error_q     <= oor_q;
`else
                    resp_data_q <= data_q;
`endif
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Line storage is not reset; a write commits on the edge that leaves RESP.
    always_ff @(posedge clock) begin
        if (commit_en) begin
            mem[idx_q] <= data_q;
        end
    end

endmodule

// File: doc/cpu_main_memory.md
CPU_MAIN_MEMORY -- requirements
Module: cpu_main_memory

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: byte-address width of the memory bus.
REQ-002 SHALL have parameter LINE_WIDTH, default 128: bits per line transfer, which is 16 bytes.
REQ-003 SHALL have parameter DEPTH_LINES, default 256: number of stored lines, a power of two.
REQ-004 SHALL have parameter LATENCY, default 4: cycles from request acceptance to response, minimum 1.
REQ-005 SHALL have port clock, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port mem_bus_available, output, 1 bit: responder idle and ready to accept a request.
REQ-008 SHALL have port mem_bus_request.read, input, 1 bit: line read request.
REQ-009 SHALL have port mem_bus_request.write, input, 1 bit: line write request.
REQ-010 SHALL have port mem_bus_request.addr, input, ADDR_WIDTH bits: byte address; bits [3:0] are ignored.
REQ-011 SHALL have port mem_bus_request.data, input, LINE_WIDTH bits: write line data.
REQ-012 SHALL have port mem_bus_response.valid, output, 1 bit: one-cycle completion pulse.
REQ-013 SHALL have port mem_bus_response.addr, output, ADDR_WIDTH bits: line-aligned address of the completed request.
REQ-014 SHALL have port mem_bus_response.data, output, LINE_WIDTH bits: read line, or echo of the written line.

Function
REQ-015 A request SHALL be accepted on a rising edge where mem_bus_available=1 and (read|write)=1.
- addr, data and the command are captured at acceptance.
- Inputs are ignored at all other times.
REQ-016 If read and write are both 1 at acceptance, write SHALL win.
REQ-017 The line index SHALL be addr[3+log2(DEPTH_LINES):4].
- Higher address bits wrap (modulo) unless REQ-026 applies.
REQ-018 The FSM SHALL have states IDLE, WAIT and RESP.
- IDLE -> WAIT on acceptance.
- WAIT counts down LATENCY-1 cycles, then -> RESP.
- RESP lasts exactly one cycle, then -> IDLE.
- When LATENCY=1, the FSM SHALL go IDLE -> RESP directly.
REQ-019 For a request accepted at edge N, mem_bus_response.valid SHALL be 1 for exactly the cycle following edge N+LATENCY.
REQ-020 mem_bus_available SHALL be 1 only in IDLE.
- It is low from the cycle after acceptance through the RESP cycle inclusive.
- Back-to-back requests are therefore spaced by at least LATENCY+1 cycles.
REQ-021 A read SHALL return the stored line as it was at acceptance time.
REQ-022 A write SHALL update the stored line at the RESP edge, and the response SHALL echo the written data.
REQ-023 Outside RESP, mem_bus_response.data and mem_bus_response.addr SHALL be held at 0.

Reset
REQ-024 While reset=0, outputs SHALL be:
- mem_bus_available=0
- mem_bus_response.valid=0
- addr=0, data=0
- FSM=IDLE, counter=0
REQ-025 Assertion of reset mid-transaction SHALL abort the transaction with no response pulse and no write commit.
- Memory array contents are not reset.
- mem_bus_available SHALL be 1 on the first cycle after deassertion.

Configuration
REQ-026 Macro CPU_MAIN_MEMORY_BOUNDS_CHECK_EN, when defined, SHALL add output mem_bus_response.error (1 bit, reset 0).
- An address with any bit above the index field set is out of range.
- Out-of-range requests complete with normal timing, error=1 and data=0.
- Writes to an out-of-range address are discarded.
- Without the macro, the port is absent and addresses wrap modulo DEPTH_LINES.

Verification
REQ-027 Reset then release with defaults -> available=1 and valid=0 one cycle after release; all outputs are 0 during reset.
REQ-028 Write addr=0x0, data=0xDDDDDDDDCCCCCCCCBBBBBBBBAAAAAAAA -> available=0 for 5 cycles; valid pulses once at edge+4 with the data echoed. A following read of 0x0 returns the same line.
REQ-029 Read addr=0x1C -> response addr=0x10, and data equals the line previously written at 0x10.
REQ-030 read=1 and write=1 together at addr=0x20, data=0x11223344 (zero-extended) -> treated as a write; a subsequent read of 0x20 returns 0x...11223344.
REQ-031 Reset asserted 2 cycles after accepting a write to 0x30 -> no valid pulse, and a later read of 0x30 returns the old contents.
REQ-032 Write to addr=0x1000 with DEPTH_LINES=256:
- With the macro: error=1, data=0, and line 0 is unchanged.
- Without the macro: the write lands in line 0.
